div_share_arbiter: RTL

- Shares one fixed-latency signed 64-bit `divide` core between NREQ independent requesters.
- Arbitrates requests round-robin and sequences the core's one-cycle Start pulse.
- Counts the core latency, because the core has no done flag, then routes the quotient back to the winning requester.
- Short-circuits zero-dividend and divide-by-zero without using the core.
- Sits between the filter/gain-update engines and the single divider instance.

---
 rtl/div_share_pkg.sv | 19 +
 rtl/div_share_arbiter_rr_pick.sv | 42 ++++
 rtl/div_share_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_share_pkg.sv
// Shared state encoding and constants for the divider-sharing arbiter.
package div_share_pkg;

    localparam int DIV_LATENCY_DEF = 102;

    // Results returned for divide-by-zero, chosen by the sign of the dividend.
    localparam logic [63:0] Q_POS_SAT = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Q_NEG_SAT = 64'h8000_0000_0000_0001;

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_BYP   = 3'd5
    } state_e;

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module div_share_arbiter_rr_pick
    import div_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] rot_s;
    logic [IDW:0]      sum_s;
    logic              hit_s;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        rot_s = {req, req} >> ptr;
        hit_s = 1'b0;
        sum_s = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit_s && rot_s[k]) begin
                hit_s = 1'b1;
                sum_s = {1'b0, ptr} + (IDW+1)'(k);
                idx   = (sum_s >= NREQ_W) ? IDW'(sum_s - NREQ_W) : IDW'(sum_s);
            end else begin
                hit_s = hit_s;
            end
        end
        gnt = hit_s ? (ONE_HOT0 << idx) : '0;
    end

    assign any = |req;

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one fixed-latency signed divider between NREQ requesters, round-robin.
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DW          = 64,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int IDW         = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_x,
    input  logic [NREQ*DW-1:0]  req_y,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_q,
    output logic                rsp_dbz,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy,
    output logic [DW-1:0]       div_x,
    output logic [DW-1:0]       div_y,
    output logic                div_start,
    input  logic [DW-1:0]       div_q
);

    localparam int              CW        = $clog2(DIV_LATENCY + 2);
    localparam logic [CW-1:0]   CNT_DRAIN = CW'(DIV_LATENCY + 1);
    localparam logic [CW-1:0]   CNT_WAIT  = CW'(DIV_LATENCY - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [DW-1:0]   POS_SAT   = (DW == 64) ? DW'(Q_POS_SAT) : {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   NEG_SAT   = (DW == 64) ? DW'(Q_NEG_SAT) : {1'b1, {(DW-2){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]  LAST_IDX  = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          st_r, st_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [IDW-1:0]  ptr_r, id_r, win_s;
    logic [NREQ-1:0] gnt_s;
    logic            any_s, accept_s, dbz_s, bypass_s;
    logic [DW-1:0]   sel_x_s, sel_y_s;
    logic            div_start_r, rsp_dbz_r, busy_r;
    logic [DW-1:0]   div_x_r, div_y_r, rsp_q_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;

    div_share_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (win_s),
        .any (any_s)
    );

    // Operand mux for the current winner (gnt_s is one-hot or zero).
    always_comb begin
        sel_x_s = '0;
        sel_y_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_x_s = sel_x_s | (req_x[i*DW +: DW] & {DW{gnt_s[i]}});
            sel_y_s = sel_y_s | (req_y[i*DW +: DW] & {DW{gnt_s[i]}});
        end
    end

    assign accept_s = (st_r == ST_IDLE) && any_s;
    assign dbz_s    = (sel_y_s == '0);
    assign bypass_s = dbz_s || (sel_x_s == '0);

    // Next-state selection.
    always_comb begin
        st_nxt_s = st_r;
        case (st_r)
            ST_DRAIN: begin
                if (cnt_r <= CNT_ONE) st_nxt_s = ST_IDLE;
                else                  st_nxt_s = ST_DRAIN;
            end
            ST_IDLE: begin
                if (!accept_s)     st_nxt_s = ST_IDLE;
                else if (bypass_s) st_nxt_s = ST_BYP;
                else               st_nxt_s = ST_ISSUE;
            end
            ST_ISSUE: st_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r <= CNT_ONE) st_nxt_s = ST_DONE;
                else                  st_nxt_s = ST_WAIT;
            end
            ST_DONE:  st_nxt_s = ST_IDLE;
            ST_BYP:   st_nxt_s = ST_IDLE;
            default:  st_nxt_s = ST_DRAIN;
        endcase
    end

    // State, latency counter, core operands and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r        <= ST_DRAIN;
            cnt_r       <= CNT_DRAIN;
            ptr_r       <= '0;
            id_r        <= '0;
            busy_r      <= 1'b1;
            div_start_r <= 1'b0;
            div_x_r     <= '0;
            div_y_r     <= '0;
            rsp_valid_r <= '0;
            rsp_q_r     <= '0;
            rsp_dbz_r   <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            st_r        <= st_nxt_s;
            busy_r      <= (st_nxt_s != ST_IDLE);
            div_start_r <= 1'b0;
            rsp_valid_r <= '0;
            case (st_r)
                ST_DRAIN: begin
                    cnt_r <= (cnt_r != '0) ? cnt_r - CNT_ONE : cnt_r;
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        id_r  <= win_s;
                        ptr_r <= (win_s == LAST_IDX) ? '0 : win_s + IDW'(1);
                        if (bypass_s) begin
                            rsp_valid_r <= gnt_s;
                            rsp_id_r    <= win_s;
                            rsp_dbz_r   <= dbz_s;
                            rsp_q_r     <= dbz_s ? (sel_x_s[DW-1] ? NEG_SAT : POS_SAT) : '0;
                        end else begin
                            div_start_r <= 1'b1;
                            div_x_r     <= sel_x_s;
                            div_y_r     <= sel_y_s;
                        end
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= CNT_WAIT;
                end
                ST_WAIT: begin
                    cnt_r <= (cnt_r != '0) ? cnt_r - CNT_ONE : cnt_r;
                    if (cnt_r <= CNT_ONE) begin
                        rsp_valid_r <= ONE_HOT0 << id_r;
                        rsp_id_r    <= id_r;
                        rsp_dbz_r   <= 1'b0;
                    end else begin
                        rsp_valid_r <= '0;
                    end
                end
                ST_DONE: begin
                    rsp_q_r <= div_q;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // The core quotient only becomes valid in the DONE cycle itself, so it is forwarded there.
    assign rsp_q     = (st_r == ST_DONE) ? div_q : rsp_q_r;
    assign req_ready = (st_r == ST_IDLE) ? gnt_s : '0;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dbz   = rsp_dbz_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;
    assign div_x     = div_x_r;
    assign div_y     = div_y_r;
    assign div_start = div_start_r;

endmodule
